// File: rtl/score_ram_arbiter.sv
// ---------------------------------------------------------------------------
// score_ram_arbiter
//
// Shares one single-port score RAM between the game-side score writer and the
// scoreboard reader. Each req/ack handshake becomes one RAM cycle. A token
// pipeline follows the fixed RAM read latency and returns read data to the
// reader with a one-cycle valid strobe.
//
// Optional feature macro: SCORE_ARB_CLEAR_EN
//   When defined, a clear sweep writes zero to addresses 0..CLR_DEPTH-1 and
//   takes priority over both requesters.
//
// Ports
//   clk        in   single clock, all logic on posedge
//   rst        in   asynchronous active-low reset
//   wr_req     in   writer request, wr_addr/wr_data held until wr_ack
//   wr_addr    in   write address (user id)
//   wr_data    in   score to write
//   wr_ack     out  pulse: write issued to RAM this cycle
//   rd_req     in   reader request, rd_addr held until rd_ack
//   rd_addr    in   read address
//   rd_ack     out  pulse: read issued to RAM this cycle
//   rd_valid   out  pulse: rd_data holds the result of an earlier read
//   rd_data    out  registered read result
//   ram_addr   out  RAM address
//   ram_wdata  out  RAM write data
//   ram_wren   out  RAM write enable
//   ram_q      in   RAM read data
//   clr_start  in   start clear sweep     (SCORE_ARB_CLEAR_EN only)
//   clr_busy   out  sweep in progress     (SCORE_ARB_CLEAR_EN only)
//   clr_done   out  pulse at sweep end    (SCORE_ARB_CLEAR_EN only)
// ---------------------------------------------------------------------------
module score_ram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 2,
  parameter int CLR_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
`ifdef SCORE_ARB_CLEAR_EN
  ,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
`endif
);

  logic              r_wr_ack;
  logic              r_rd_ack;
  logic              r_rd_valid;
  logic              r_ram_wren;
  logic              r_last_rd;    // 1: reader was granted last, 0: writer
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [RD_LAT-1:0] r_tok;        // read tokens in flight, bit RD_LAT-1 exits

  logic              w_wr_elig;
  logic              w_rd_elig;
  logic              w_gnt_wr;
  logic              w_gnt_rd;
  logic              w_hold;       // sweep owns the RAM next cycle
  logic              w_clr_wr;     // sweep write issued next cycle
  logic [ADDR_W-1:0] w_clr_addr;

  // A request whose ack is high this cycle is the stale re-sample of an
  // already-served transaction, so it is not eligible.
  assign w_wr_elig = wr_req & ~r_wr_ack;
  assign w_rd_elig = rd_req & ~r_rd_ack;

`ifdef SCORE_ARB_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLR_DEPTH - 1);

  logic              r_clr_busy;
  logic              r_clr_done;
  logic [ADDR_W-1:0] r_clr_cnt;    // address being zeroed this cycle
  logic              w_clr_go;
  logic              w_clr_last;

  assign w_clr_go   = clr_start & ~r_clr_busy;
  assign w_clr_last = r_clr_busy & (r_clr_cnt == CLR_LAST);
  assign w_hold     = w_clr_go | r_clr_busy;
  assign w_clr_wr   = w_clr_go | (r_clr_busy & ~w_clr_last);
  assign w_clr_addr = w_clr_go ? {ADDR_W{1'b0}} : (r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1});

  // Sweep sequencer: start, advance one address per cycle, end with done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
      r_clr_cnt  <= {ADDR_W{1'b0}};
    end else begin
      r_clr_done <= w_clr_last;
      if (w_clr_go) begin
        r_clr_busy <= 1'b1;
        r_clr_cnt  <= {ADDR_W{1'b0}};
      end else if (w_clr_last) begin
        r_clr_busy <= 1'b0;
      end else if (r_clr_busy) begin
        r_clr_cnt  <= r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        r_clr_cnt  <= r_clr_cnt;
      end
    end
  end

  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;
`else
  assign w_hold     = 1'b0;
  assign w_clr_wr   = 1'b0;
  assign w_clr_addr = {ADDR_W{1'b0}};
`endif

  // Grant decision: sweep blocks everyone, a tie goes to whoever was not last.
  always_comb begin
    w_gnt_wr = 1'b0;
    w_gnt_rd = 1'b0;
    if (w_hold) begin
      w_gnt_wr = 1'b0;
      w_gnt_rd = 1'b0;
    end else if (w_wr_elig && w_rd_elig) begin
      if (r_last_rd) begin
        w_gnt_wr = 1'b1;
      end else begin
        w_gnt_rd = 1'b1;
      end
    end else if (w_wr_elig) begin
      w_gnt_wr = 1'b1;
    end else if (w_rd_elig) begin
      w_gnt_rd = 1'b1;
    end else begin
      w_gnt_wr = 1'b0;
      w_gnt_rd = 1'b0;
    end
  end

  // RAM drive, acks and round-robin pointer; ram_addr holds across idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ack    <= 1'b0;
      r_rd_ack    <= 1'b0;
      r_ram_wren  <= 1'b0;
      r_ram_addr  <= {ADDR_W{1'b0}};
      r_ram_wdata <= {DATA_W{1'b0}};
      r_last_rd   <= 1'b0;
    end else begin
      r_wr_ack   <= w_gnt_wr;
      r_rd_ack   <= w_gnt_rd;
      r_ram_wren <= w_gnt_wr | w_clr_wr;
      if (w_clr_wr) begin
        r_ram_addr  <= w_clr_addr;
        r_ram_wdata <= {DATA_W{1'b0}};
      end else if (w_gnt_wr) begin
        r_ram_addr  <= wr_addr;
        r_ram_wdata <= wr_data;
      end else if (w_gnt_rd) begin
        r_ram_addr  <= rd_addr;
      end else begin
        r_ram_addr  <= r_ram_addr;
      end
      if (w_gnt_wr) begin
        r_last_rd <= 1'b0;
      end else if (w_gnt_rd) begin
        r_last_rd <= 1'b1;
      end else begin
        r_last_rd <= r_last_rd;
      end
    end
  end

  // Read latency tracker: a token enters with the grant and exits RD_LAT
  // cycles later, at which point ram_q carries that read's data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tok      <= {RD_LAT{1'b0}};
      r_rd_valid <= 1'b0;
      r_rd_data  <= {DATA_W{1'b0}};
    end else begin
      r_tok[0] <= w_gnt_rd;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tok[i] <= r_tok[i-1];
      end
      r_rd_valid <= r_tok[RD_LAT-1];
      if (r_tok[RD_LAT-1]) begin
        r_rd_data <= ram_q;
      end else begin
        r_rd_data <= r_rd_data;
      end
    end
  end

  assign wr_ack    = r_wr_ack;
  assign rd_ack    = r_rd_ack;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_wren  = r_ram_wren;

endmodule

// File: tb/tb_score_ram_arbiter.sv
module tb_score_ram_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int CD  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = 16'h0000;
  logic [DW-1:0] wr_data = 16'h0000;
  logic          wr_ack;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = 16'h0000;
  logic          rd_ack;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] ram_q;
`ifdef SCORE_ARB_CLEAR_EN
  logic          clr_start = 1'b0;
  logic          clr_busy;
  logic          clr_done;
`endif

  int n_checks = 0;
  int n_errors = 0;

  score_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .CLR_DEPTH(CD)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
    .ram_q(ram_q)
`ifdef SCORE_ARB_CLEAR_EN
    , .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: unwritten words read as 16'hA000 + addr; q follows the
  // address registered by the arbiter one clock later.
  logic [DW-1:0] mem   [0:255];
  logic [255:0]  wrote = 256'd0;
  always @(posedge clk) begin
    if (ram_wren) begin
      mem[ram_addr[7:0]]   <= ram_wdata;
      wrote[ram_addr[7:0]] <= 1'b1;
    end
    ram_q <= wrote[ram_addr[7:0]] ? mem[ram_addr[7:0]] : (16'hA000 + {8'h00, ram_addr[7:0]});
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_ack"},   32'(wr_ack),    32'd0);
    chk({tag, "_rd_ack"},   32'(rd_ack),    32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid),  32'd0);
    chk({tag, "_rd_data"},  32'(rd_data),   32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr),  32'd0);
    chk({tag, "_ram_wd"},   32'(ram_wdata), 32'd0);
    chk({tag, "_ram_wren"}, 32'(ram_wren),  32'd0);
  endtask

  initial begin
    int nw;
    int nr;
    int nxt;
    int seen;

    // reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // single write
    wr_addr = 16'h0005; wr_data = 16'h0042; wr_req = 1'b1;
    @(negedge clk);
    chk("wr_ack",   32'(wr_ack),    32'd1);
    chk("wr_wren",  32'(ram_wren),  32'd1);
    chk("wr_addr",  32'(ram_addr),  32'h5);
    chk("wr_wdata", 32'(ram_wdata), 32'h42);
    chk("wr_rdack", 32'(rd_ack),    32'd0);
    wr_req = 1'b0;
    @(negedge clk);
    chk("wr_ack_off",  32'(wr_ack),   32'd0);
    chk("wr_wren_off", 32'(ram_wren), 32'd0);
    chk("idle_addr",   32'(ram_addr), 32'h5);

    // single read, data returns two cycles after the ack
    rd_addr = 16'h0005; rd_req = 1'b1;
    @(negedge clk);
    chk("rd_ack",  32'(rd_ack),   32'd1);
    chk("rd_addr", 32'(ram_addr), 32'h5);
    chk("rd_wren", 32'(ram_wren), 32'd0);
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_ack_off", 32'(rd_ack),   32'd0);
    chk("rd_early",   32'(rd_valid), 32'd0);
    @(negedge clk);
    chk("rd_valid", 32'(rd_valid), 32'd1);
    chk("rd_data",  32'(rd_data),  32'h42);
    @(negedge clk);
    chk("rd_valid_off", 32'(rd_valid), 32'd0);

    // contention right after reset: reader wins the first tie, then alternate
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wr_addr = 16'h0010; wr_data = 16'h1234; wr_req = 1'b1;
    rd_addr = 16'h0005; rd_req = 1'b1;
    nw = 0; nr = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("cont_rd",   32'(rd_ack),            (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_wr",   32'(wr_ack),            (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("cont_busy", 32'(ram_wren | rd_ack), 32'd1);
      nw += int'(wr_ack);
      nr += int'(rd_ack);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("cont_nw", 32'(nw), 32'd4);
    chk("cont_nr", 32'(nr), 32'd4);
    repeat (4) @(negedge clk);

    // back-to-back reads of 0..3, requester advances address on each ack
    rd_addr = 16'h0000; rd_req = 1'b1; nxt = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("b2b_ack",   32'(rd_ack),   (c % 2 == 1 && c <= 7) ? 32'd1 : 32'd0);
      chk("b2b_valid", 32'(rd_valid), (c % 2 == 1 && c >= 3) ? 32'd1 : 32'd0);
      if (c % 2 == 1 && c >= 3) begin
        chk("b2b_data", 32'(rd_data), 32'hA000 + 32'((c - 3) / 2));
      end
      if (rd_ack) begin
        if (nxt < 4) begin
          rd_addr = 16'(nxt);
          nxt++;
        end else begin
          rd_req = 1'b0;
        end
      end
    end
    repeat (2) @(negedge clk);

    // reset while a read is in flight and another is returning
    rd_addr = 16'h0001; rd_req = 1'b1;
    @(negedge clk);
    chk("mid_ack1", 32'(rd_ack), 32'd1);
    rd_addr = 16'h0002;
    @(negedge clk);
    @(negedge clk);
    chk("mid_ack2",   32'(rd_ack),   32'd1);
    chk("mid_valid1", 32'(rd_valid), 32'd1);
    chk("mid_data1",  32'(rd_data),  32'hA001);
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(rd_valid);
    end
    chk("post_rst_valid", 32'(seen), 32'd0);

`ifdef SCORE_ARB_CLEAR_EN
    // clear sweep blocks a pending write until after the done pulse
    clr_start = 1'b1;
    wr_addr = 16'h0033; wr_data = 16'h0077; wr_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        chk("clr_busy",  32'(clr_busy),  32'd1);
        chk("clr_done",  32'(clr_done),  32'd0);
        chk("clr_wren",  32'(ram_wren),  32'd1);
        chk("clr_addr",  32'(ram_addr),  32'(c - 1));
        chk("clr_wdata", 32'(ram_wdata), 32'd0);
        chk("clr_wrack", 32'(wr_ack),    32'd0);
      end else if (c == 9) begin
        chk("clr_end_busy", 32'(clr_busy), 32'd0);
        chk("clr_end_done", 32'(clr_done), 32'd1);
        chk("clr_end_wren", 32'(ram_wren), 32'd0);
        chk("clr_end_ack",  32'(wr_ack),   32'd0);
      end else begin
        chk("clr_post_ack",  32'(wr_ack),    32'd1);
        chk("clr_post_addr", 32'(ram_addr),  32'h33);
        chk("clr_post_wd",   32'(ram_wdata), 32'h77);
        chk("clr_post_done", 32'(clr_done),  32'd0);
        wr_req = 1'b0;
      end
      if (c == 2) begin
        clr_start = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
